// File: rtl/genius_pkg.sv
// Shared definitions for the Genius (Simon) game controller: state codes,
// default playback pacing and bit positions of the strobe debug bus.
package genius_pkg;

  typedef enum logic [2:0] {
    ST_INIT       = 3'd0,
    ST_SETUP      = 3'd1,
    ST_PLAY_FPGA  = 3'd2,
    ST_PLAY_USER  = 3'd3,
    ST_CHECK      = 3'd4,
    ST_NEXT_ROUND = 3'd5,
    ST_RESULT     = 3'd6
  } state_t;

  localparam int SHOW_TICKS_DEF = 4;

  // Strobe bus layout, LSB first.
  localparam int STB_SEL = 0;
  localparam int STB_E4  = 1;
  localparam int STB_E3  = 2;
  localparam int STB_E2  = 3;
  localparam int STB_E1  = 4;
  localparam int STB_R2  = 5;
  localparam int STB_R1  = 6;
  localparam int NUM_STB = 7;

endpackage

// File: rtl/genius_pace_timer.sv
// Playback pacing counter: counts enabled cycles 0..SHOW_TICKS-1 and raises
// tick combinationally on the last one, wrapping back to zero.
module genius_pace_timer #(
  parameter int SHOW_TICKS = genius_pkg::SHOW_TICKS_DEF,
  parameter int PACE_W     = $clog2(SHOW_TICKS)
) (
  input  logic clk,
  input  logic R,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [PACE_W-1:0] LAST = PACE_W'(SHOW_TICKS - 1);

  logic [PACE_W-1:0] cnt_reg;

  assign tick = en && (cnt_reg == LAST);

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= tick ? '0 : cnt_reg + PACE_W'(1);
    end
  end

endmodule

// File: rtl/genius_control.sv
// Game-sequencing FSM for the Genius memory game: paces FPGA playback,
// judges user keys and drives the datapath counter strobes.
module genius_control
  import genius_pkg::*;
#(
  parameter int SHOW_TICKS = SHOW_TICKS_DEF,
  parameter int PACE_W     = $clog2(SHOW_TICKS)
) (
  input  logic       clk,
  input  logic       R,
  input  logic       enter,
  input  logic       key_valid,
  input  logic       match,
  input  logic       end_FPGA,
  input  logic       end_User,
  input  logic       end_round,
  input  logic       end_time,
  output logic       R1,
  output logic       R2,
  output logic       E1,
  output logic       E2,
  output logic       E3,
  output logic       E4,
  output logic       SEL,
  output logic       win,
  output logic       lose,
  output logic [2:0] state
);

  state_t               state_reg;
  logic                 win_reg;
  logic                 lose_reg;
  logic                 pace_clr;
  logic                 pace_en;
  logic                 pace_tick;
  logic [NUM_STB-1:0]   stb;

  // Each round restarts playback from a fresh pace count.
  assign pace_clr = (state_reg == ST_SETUP) || (state_reg == ST_NEXT_ROUND);
  assign pace_en  = (state_reg == ST_PLAY_FPGA);

  genius_pace_timer #(
    .SHOW_TICKS (SHOW_TICKS),
    .PACE_W     (PACE_W)
  ) u_pace (
    .clk  (clk),
    .R    (R),
    .clr  (pace_clr),
    .en   (pace_en),
    .tick (pace_tick)
  );

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state_reg <= ST_INIT;
      win_reg   <= 1'b0;
      lose_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_INIT: begin
          if (enter) state_reg <= ST_SETUP;
        end
        ST_SETUP: begin
          state_reg <= ST_PLAY_FPGA;
        end
        ST_PLAY_FPGA: begin
          if (pace_tick && end_FPGA) state_reg <= ST_PLAY_USER;
        end
        ST_PLAY_USER: begin
          // A key press takes priority over a simultaneous timeout.
          if (key_valid) begin
            if (!match) begin
              state_reg <= ST_RESULT;
              lose_reg  <= 1'b1;
            end else if (end_User) begin
              state_reg <= ST_CHECK;
            end
          end else if (end_time) begin
            state_reg <= ST_RESULT;
            lose_reg  <= 1'b1;
          end
        end
        ST_CHECK: begin
          if (end_round) begin
            state_reg <= ST_RESULT;
            win_reg   <= 1'b1;
          end else begin
            state_reg <= ST_NEXT_ROUND;
          end
        end
        ST_NEXT_ROUND: begin
          state_reg <= ST_PLAY_FPGA;
        end
        ST_RESULT: begin
          if (enter) begin
            state_reg <= ST_INIT;
            win_reg   <= 1'b0;
            lose_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_INIT;
          win_reg   <= 1'b0;
          lose_reg  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    stb = '0;
    case (state_reg)
      ST_INIT: begin
        stb[STB_R1] = 1'b1;
        stb[STB_R2] = 1'b1;
      end
      ST_SETUP: begin
        stb[STB_E1] = 1'b1;
        stb[STB_R2] = 1'b1;
      end
      ST_PLAY_FPGA: begin
        stb[STB_E3] = pace_tick && !end_FPGA;
      end
      ST_PLAY_USER: begin
        stb[STB_SEL] = 1'b1;
        stb[STB_E4]  = key_valid && match && !end_User;
      end
      ST_NEXT_ROUND: begin
        stb[STB_E2] = 1'b1;
        stb[STB_R2] = 1'b1;
      end
      ST_CHECK, ST_RESULT: begin
        stb = '0;
      end
      default: begin
        stb[STB_R1] = 1'b1;
        stb[STB_R2] = 1'b1;
      end
    endcase
    // Hold the datapath in reset while R is asserted, whatever the state.
    if (R) begin
      stb         = '0;
      stb[STB_R1] = 1'b1;
      stb[STB_R2] = 1'b1;
    end
  end

  assign R1    = stb[STB_R1];
  assign R2    = stb[STB_R2];
  assign E1    = stb[STB_E1];
  assign E2    = stb[STB_E2];
  assign E3    = stb[STB_E3];
  assign E4    = stb[STB_E4];
  assign SEL   = stb[STB_SEL];
  assign win   = win_reg;
  assign lose  = lose_reg;
  assign state = state_reg;

endmodule

// File: tb/tb_genius_control.sv
// Directed bench for genius_control: walks reset, playback pacing, user entry,
// lose/win outcomes and a mid-game reset with hand-computed expectations.
module tb_genius_control;

  logic       clk = 1'b0;
  logic       R, enter, key_valid, match, end_FPGA, end_User, end_round, end_time;
  logic       R1, R2, E1, E2, E3, E4, SEL, win, lose;
  logic [2:0] state;
  logic [6:0] stb;

  int errors = 0;
  int checks = 0;

  // Strobe patterns as {R1,R2,E1,E2,E3,E4,SEL}
  localparam logic [6:0] P_INIT  = 7'b1100000;
  localparam logic [6:0] P_SETUP = 7'b0110000;
  localparam logic [6:0] P_NONE  = 7'b0000000;
  localparam logic [6:0] P_E3    = 7'b0000100;
  localparam logic [6:0] P_SEL   = 7'b0000001;
  localparam logic [6:0] P_E4    = 7'b0000011;
  localparam logic [6:0] P_NEXT  = 7'b0101000;

  assign stb = {R1, R2, E1, E2, E3, E4, SEL};

  always #5 clk = ~clk;

  genius_control #(.SHOW_TICKS(4)) dut (
    .clk       (clk),
    .R         (R),
    .enter     (enter),
    .key_valid (key_valid),
    .match     (match),
    .end_FPGA  (end_FPGA),
    .end_User  (end_User),
    .end_round (end_round),
    .end_time  (end_time),
    .R1        (R1),
    .R2        (R2),
    .E1        (E1),
    .E2        (E2),
    .E3        (E3),
    .E4        (E4),
    .SEL       (SEL),
    .win       (win),
    .lose      (lose),
    .state     (state)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // From INIT: enter, SETUP, then four PLAY_FPGA cycles with end_FPGA=1.
  task automatic go_play_user();
    enter = 1'b1;
    next();
    enter = 1'b0;
    next();
    end_FPGA = 1'b1;
    for (int i = 0; i < 4; i++) next();
    end_FPGA = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    R = 1'b1; enter = 1'b0; key_valid = 1'b0; match = 1'b0;
    end_FPGA = 1'b0; end_User = 1'b0; end_round = 1'b0; end_time = 1'b0;
    #1;
    chk("reset_state", 8'(state), 8'd0);
    chk("reset_stb",   8'(stb),   8'(P_INIT));
    chk("reset_wl",    8'({win, lose}), 8'd0);
    next(); next();
    R = 1'b0;

    // Start: INIT -> SETUP -> PLAY_FPGA, E3 every 4 cycles
    enter = 1'b1; #1;
    chk("init_state", 8'(state), 8'd0);
    chk("init_stb",   8'(stb),   8'(P_INIT));
    next(); enter = 1'b0; #1;
    chk("setup_state", 8'(state), 8'd1);
    chk("setup_stb",   8'(stb),   8'(P_SETUP));
    next();
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("play_state_%0d", i), 8'(state), 8'd2);
      chk($sformatf("play_stb_%0d", i),   8'(stb),   8'((i % 4 == 3) ? P_E3 : P_NONE));
      next();
    end

    // end_FPGA at terminal count -> PLAY_USER with no E3
    end_FPGA = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("last_stb_%0d", i), 8'(stb), 8'(P_NONE));
      next();
    end
    end_FPGA = 1'b0; #1;
    chk("user_state", 8'(state), 8'd3);
    chk("user_stb",   8'(stb),   8'(P_SEL));

    // Key and timeout together: key wins, E4 pulses, stay
    key_valid = 1'b1; match = 1'b1; end_User = 1'b0; end_time = 1'b1; #1;
    chk("key_time_stb", 8'(stb), 8'(P_E4));
    next();
    end_time = 1'b0; end_User = 1'b1; #1;
    chk("key_time_state", 8'(state), 8'd3);
    chk("key_time_lose",  8'(lose),  8'd0);
    chk("last_key_stb",   8'(stb),   8'(P_SEL));
    next();
    key_valid = 1'b0; match = 1'b0; end_User = 1'b0; end_round = 1'b0; #1;
    chk("check_state", 8'(state), 8'd4);
    next(); #1;
    chk("next_state", 8'(state), 8'd5);
    chk("next_stb",   8'(stb),   8'(P_NEXT));
    next(); #1;
    chk("round2_state", 8'(state), 8'd2);
    chk("round2_stb",   8'(stb),   8'(P_NONE));

    // Round 2: wrong key -> lose
    end_FPGA = 1'b1;
    for (int i = 0; i < 4; i++) next();
    end_FPGA = 1'b0;
    key_valid = 1'b1; match = 1'b0; #1;
    chk("wrong_stb", 8'(stb), 8'(P_SEL));
    next();
    key_valid = 1'b0; #1;
    chk("lose_state", 8'(state), 8'd6);
    chk("lose_wl",    8'({win, lose}), 8'd1);
    chk("result_stb", 8'(stb), 8'(P_NONE));
    enter = 1'b1;
    next();
    enter = 1'b0; #1;
    chk("restart_state", 8'(state), 8'd0);
    chk("restart_wl",    8'({win, lose}), 8'd0);

    // Timeout without a key -> lose
    go_play_user(); #1;
    chk("to_user_state", 8'(state), 8'd3);
    end_time = 1'b1;
    next();
    end_time = 1'b0; #1;
    chk("timeout_state", 8'(state), 8'd6);
    chk("timeout_wl",    8'({win, lose}), 8'd1);
    enter = 1'b1;
    next();
    enter = 1'b0;

    // Final round: match + end_User, then end_round -> win held
    go_play_user();
    key_valid = 1'b1; match = 1'b1; end_User = 1'b1;
    next();
    key_valid = 1'b0; match = 1'b0; end_User = 1'b0; end_round = 1'b1; #1;
    chk("final_check_state", 8'(state), 8'd4);
    next();
    end_round = 1'b0;
    for (int i = 0; i < 20; i++) begin
      key_valid = 1'($urandom_range(0, 1));
      match     = 1'($urandom_range(0, 1));
      end_User  = 1'($urandom_range(0, 1));
      end_time  = 1'($urandom_range(0, 1));
      #1;
      chk($sformatf("win_state_%0d", i), 8'(state), 8'd6);
      chk($sformatf("win_wl_%0d", i),    8'({win, lose}), 8'd2);
      chk($sformatf("win_stb_%0d", i),   8'(stb), 8'(P_NONE));
      next();
    end
    key_valid = 1'b0; match = 1'b0; end_User = 1'b0; end_time = 1'b0;
    enter = 1'b1;
    next();
    enter = 1'b0; #1;
    chk("win_exit_state", 8'(state), 8'd0);
    chk("win_exit_wl",    8'({win, lose}), 8'd0);

    // Reset mid-PLAY_FPGA with pace count at 2
    enter = 1'b1;
    next();
    enter = 1'b0;
    next(); next(); next();
    R = 1'b1; #1;
    chk("midreset_state", 8'(state), 8'd0);
    chk("midreset_stb",   8'(stb),   8'(P_INIT));
    next();
    R = 1'b0;
    enter = 1'b1;
    next();
    enter = 1'b0;
    next();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("post_reset_stb_%0d", i), 8'(stb), 8'((i == 3) ? P_E3 : P_NONE));
      next();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
